// File: rtl/iomem_stream_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : iomem_stream_bridge_pkg
//  Brief    : Shared register map, STATUS bit positions and defaults for the
//             iomem <-> byte-stream bridge.
//  Revision : 1.0 - initial release
// ============================================================================
package iomem_stream_bridge_pkg;

  // Page (iomem_addr[31:24]) that selects the bridge unless overridden
  localparam logic [7:0] ADDR_PAGE_DEFAULT = 8'h05;

  // Register offsets, decoded from iomem_addr[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  // STATUS register bit positions
  localparam int STAT_TX_FULL    = 0;
  localparam int STAT_TX_EMPTY   = 1;
  localparam int STAT_RX_EMPTY   = 2;
  localparam int STAT_RX_FULL    = 3;
  localparam int STAT_TX_OVF     = 4;
  localparam int STAT_TX_CNT_LSB = 8;
  localparam int STAT_RX_CNT_LSB = 16;

  // DATA read response when the RX FIFO holds nothing
  localparam logic [31:0] RDATA_RX_EMPTY = 32'h8000_0000;

  // Counts are reported in 8-bit fields; a 256-deep FIFO can hold 256, which
  // saturates to 255 here (the full bit tells the two cases apart).
  function automatic logic [7:0] count_field(input logic [8:0] cnt);
    return (cnt > 9'd255) ? 8'hFF : cnt[7:0];
  endfunction

endpackage : iomem_stream_bridge_pkg
`default_nettype wire

// File: rtl/iomem_stream_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : iomem_stream_bridge_if
//  Brief    : iomem bus plus TX/RX byte-stream handshakes of the bridge.
//             'slave' is the bridge's view, 'master' the surrounding system.
//  Revision : 1.0 - initial release
// ============================================================================
interface iomem_stream_bridge_if;

  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata,
    output tx_data, tx_valid,
    input  tx_ready,
    input  rx_data, rx_valid,
    output rx_ready
  );

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata,
    input  tx_data, tx_valid,
    output tx_ready,
    output rx_data, rx_valid,
    input  rx_ready
  );

endinterface : iomem_stream_bridge_if
`default_nettype wire

// File: rtl/iomem_stream_bridge_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : stream_fifo
//  Brief    : Show-ahead synchronous FIFO with occupancy count. Full/empty
//             derive from the count registered at the start of the cycle, so
//             a push into a full FIFO is refused even if a pop happens too.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_r;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_r == CW'(DEPTH));
  assign empty   = (count_r == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign count   = count_r;

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count_r <= count_r + CW'(1);
      else if (pop_ok && !push_ok) count_r <= count_r - CW'(1);
    end
  end

endmodule : stream_fifo
`default_nettype wire

// File: rtl/iomem_stream_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : iomem_stream_bridge
//  Brief    : Memory-mapped bridge between a PicoRV32-style iomem bus and a
//             pair of byte streams (TX to host link, RX from host link).
//             DATA register pushes TX / pops RX, STATUS reports FIFO state.
//  Revision : 1.0 - initial release
// ============================================================================
module iomem_stream_bridge
  import iomem_stream_bridge_pkg::*;
#(
  parameter logic [7:0] ADDR_PAGE  = ADDR_PAGE_DEFAULT,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  iomem_stream_bridge_if.slave  bus,
  output logic                  irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  generate
    if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 256) ||
        ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two in 2..256");
    end
  endgenerate

  logic          ready_r;
  logic [31:0]   rdata_r;
  logic [31:0]   rdata_next;
  logic          tx_ovf_r;

  logic          sel;
  logic          is_write;
  logic [1:0]    reg_off;
  logic          data_wr;
  logic          data_rd;
  logic          stat_wr;

  logic          tx_push;
  logic          tx_pop;
  logic [7:0]    tx_head;
  logic          tx_full;
  logic          tx_empty;
  logic [CW-1:0] tx_count;

  logic          rx_push;
  logic          rx_pop;
  logic [7:0]    rx_head;
  logic          rx_full;
  logic          rx_empty;
  logic [CW-1:0] rx_count;

  logic [31:0]   status_word;
  logic          unused_bits;

  // A request is taken once: ready_r masks the cycle in which we answer
  assign sel      = bus.iomem_valid && !ready_r && (bus.iomem_addr[31:24] == ADDR_PAGE);
  assign is_write = |bus.iomem_wstrb;
  assign reg_off  = bus.iomem_addr[3:2];
  assign data_wr  = sel && is_write && bus.iomem_wstrb[0] && (reg_off == REG_DATA);
  assign data_rd  = sel && !is_write && (reg_off == REG_DATA);
  assign stat_wr  = sel && is_write && bus.iomem_wstrb[0] && (reg_off == REG_STATUS);

  assign tx_push  = data_wr;
  assign tx_pop   = !tx_empty && bus.tx_ready;
  assign rx_push  = bus.rx_valid && !rx_full;
  assign rx_pop   = data_rd;

  assign unused_bits = ^{bus.iomem_addr[23:4], bus.iomem_addr[1:0], bus.iomem_wdata[31:8]};

  stream_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (tx_push),
    .push_data (bus.iomem_wdata[7:0]),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  stream_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (rx_push),
    .push_data (bus.rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  assign bus.tx_valid    = !tx_empty;
  assign bus.tx_data     = tx_head;
  assign bus.rx_ready    = !rx_full;
  assign bus.iomem_ready = ready_r;
  assign bus.iomem_rdata = rdata_r;
  assign irq             = !rx_empty;

  // Assemble STATUS from the registered FIFO state
  always_comb begin
    status_word                                = '0;
    status_word[STAT_TX_FULL]                  = tx_full;
    status_word[STAT_TX_EMPTY]                 = tx_empty;
    status_word[STAT_RX_EMPTY]                 = rx_empty;
    status_word[STAT_RX_FULL]                  = rx_full;
    status_word[STAT_TX_OVF]                   = tx_ovf_r;
    status_word[STAT_TX_CNT_LSB +: 8]          = count_field(9'(tx_count));
    status_word[STAT_RX_CNT_LSB +: 8]          = count_field(9'(rx_count));
  end

  // Read-data mux; writes and unmapped offsets answer zero
  always_comb begin
    rdata_next = '0;
    if (sel && !is_write) begin
      case (reg_off)
        REG_DATA:   rdata_next = rx_empty ? RDATA_RX_EMPTY : {24'b0, rx_head};
        REG_STATUS: rdata_next = status_word;
        default:    rdata_next = '0;
      endcase
    end
  end

  // One-cycle completion pulse with the response captured alongside it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_r <= 1'b0;
      rdata_r <= '0;
    end else begin
      ready_r <= sel;
      rdata_r <= rdata_next;
    end
  end

  // Sticky TX overflow: set on a refused DATA write, cleared by W1C on STATUS
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_ovf_r <= 1'b0;
    end else if (data_wr && tx_full) begin
      tx_ovf_r <= 1'b1;
    end else if (stat_wr && bus.iomem_wdata[STAT_TX_OVF]) begin
      tx_ovf_r <= 1'b0;
    end
  end

endmodule : iomem_stream_bridge
`default_nettype wire

// File: tb/tb_iomem_stream_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iomem_stream_bridge
//  Brief    : Self-checking bench for iomem_stream_bridge (scoreboard queues
//             for TX stream bytes and RX bytes read back over the bus).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iomem_stream_bridge;

  localparam logic [31:0] A_DATA   = 32'h0500_0000;
  localparam logic [31:0] A_STATUS = 32'h0500_0004;

  logic clk;
  logic resetn;
  logic irq;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  iomem_stream_bridge_if bus_if ();

  iomem_stream_bridge #(.ADDR_PAGE(8'h05), .FIFO_DEPTH(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if.slave),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All tasks start and end at a point 1 time unit after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_access(input logic [31:0] addr, input logic [3:0] wstrb,
                            input logic [31:0] wdata, output logic [31:0] rdata);
    bit got;
    got = 1'b0;
    rdata = '0;
    bus_if.iomem_valid = 1'b1;
    bus_if.iomem_addr  = addr;
    bus_if.iomem_wstrb = wstrb;
    bus_if.iomem_wdata = wdata;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (bus_if.iomem_ready === 1'b1) begin
        got = 1'b1;
        rdata = bus_if.iomem_rdata;
      end
    end
    bus_if.iomem_valid = 1'b0;
    bus_if.iomem_wstrb = 4'h0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL bus_timeout addr=%h no iomem_ready within 8 cycles", addr);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] dummy;
    bus_access(addr, 4'h1, wdata, dummy);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] rdata);
    bus_access(addr, 4'h0, 32'h0, rdata);
  endtask

  task automatic rx_send(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data  = b;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (bus_if.rx_ready === 1'b1) ok = 1'b1;
      step();
    end
    bus_if.rx_valid = 1'b0;
    if (ok) rx_exp.push_back(b);
    else begin
      checks++;
      errors++;
      $display("FAIL rx_send_timeout byte=%h rx_ready stayed low", b);
    end
  endtask

  // Drain TX with tx_ready high, comparing each handshaken byte to the queue
  task automatic tx_drain(input string tag);
    int guard;
    guard = 0;
    bus_if.tx_ready = 1'b1;
    while (tx_exp.size() > 0 && guard < 40) begin
      if (bus_if.tx_valid === 1'b1) begin
        logic [7:0] e;
        e = tx_exp.pop_front();
        checks++;
        if (bus_if.tx_data !== e) begin
          errors++;
          $display("FAIL %s_tx_data got=%h exp=%h", tag, bus_if.tx_data, e);
        end
      end
      step();
      guard++;
    end
    checks++;
    if (tx_exp.size() != 0) begin
      errors++;
      $display("FAIL %s_tx_drain_timeout remaining=%0d exp=0", tag, tx_exp.size());
      tx_exp.delete();
    end
    checks++;
    if (bus_if.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_tx_valid_after_drain got=%b exp=0", tag, bus_if.tx_valid);
    end
    bus_if.tx_ready = 1'b0;
  endtask

  task automatic rx_read_all(input string tag);
    logic [31:0] rd;
    while (rx_exp.size() > 0) begin
      logic [31:0] e;
      e = {24'b0, rx_exp.pop_front()};
      bus_read(A_DATA, rd);
      checks++;
      if (rd !== e) begin
        errors++;
        $display("FAIL %s_rx_read got=%h exp=%h", tag, rd, e);
      end
    end
  endtask

  task automatic expect_status(input string tag, input logic [31:0] e);
    logic [31:0] rd;
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== e) begin
      errors++;
      $display("FAIL %s_status got=%h exp=%h", tag, rd, e);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) step();
    checks++;
    if (bus_if.iomem_ready !== 1'b0 || bus_if.iomem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus got ready=%b rdata=%h exp ready=0 rdata=0",
               bus_if.iomem_ready, bus_if.iomem_rdata);
    end
    checks++;
    if (bus_if.tx_valid !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got tx_valid=%b irq=%b exp 0 0", bus_if.tx_valid, irq);
    end
    resetn = 1'b1;
    step();
    checks++;
    if (bus_if.rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_rx_ready got=%b exp=1", bus_if.rx_ready);
    end
    expect_status("reset", 32'h0000_0006);
  endtask

  task automatic test_tx_basic();
    bus_if.tx_ready = 1'b0;
    bus_write(A_DATA, 32'h0000_0041); tx_exp.push_back(8'h41);
    bus_write(A_DATA, 32'h0000_0042); tx_exp.push_back(8'h42);
    expect_status("tx_basic", 32'h0000_0204);
    tx_drain("tx_basic");
  endtask

  task automatic test_tx_overflow();
    bus_if.tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus_write(A_DATA, 32'h0000_0060 + 32'(i));
      if (i < 8) tx_exp.push_back(8'h60 + 8'(i));
    end
    expect_status("tx_ovf_set", 32'h0000_0815);
    bus_write(A_STATUS, 32'h0000_0010);
    expect_status("tx_ovf_clr", 32'h0000_0805);
    tx_drain("tx_ovf");
  endtask

  task automatic test_rx_fill();
    logic [31:0] rd;
    for (int i = 0; i < 8; i++) rx_send(8'hA0 + 8'(i));
    checks++;
    if (bus_if.rx_ready !== 1'b0 || irq !== 1'b1) begin
      errors++;
      $display("FAIL rx_full_flags got rx_ready=%b irq=%b exp 0 1", bus_if.rx_ready, irq);
    end
    expect_status("rx_full", 32'h0008_000A);
    rx_read_all("rx_fill");
    bus_read(A_DATA, rd);
    checks++;
    if (rd !== 32'h8000_0000) begin
      errors++;
      $display("FAIL rx_empty_read got=%h exp=80000000", rd);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL rx_irq_clear got=%b exp=0", irq);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    bit saw;
    for (int i = 0; i < 4; i++) rx_send(8'h10 + 8'(i));
    // Bus DATA read and RX stream push land on the same edge
    bus_if.iomem_valid = 1'b1;
    bus_if.iomem_addr  = A_DATA;
    bus_if.iomem_wstrb = 4'h0;
    bus_if.rx_valid    = 1'b1;
    bus_if.rx_data     = 8'h99;
    step();
    bus_if.rx_valid    = 1'b0;
    bus_if.iomem_valid = 1'b0;
    e = rx_exp.pop_front();
    rx_exp.push_back(8'h99);
    checks++;
    if (bus_if.iomem_ready !== 1'b1 || bus_if.iomem_rdata !== {24'b0, e}) begin
      errors++;
      $display("FAIL simul_read got ready=%b rdata=%h exp ready=1 rdata=%h",
               bus_if.iomem_ready, bus_if.iomem_rdata, {24'b0, e});
    end
    step();
    expect_status("simul_count", 32'h0004_0002);
    rx_read_all("simul");
    // Neighbouring page must be ignored entirely
    saw = 1'b0;
    bus_if.iomem_valid = 1'b1;
    bus_if.iomem_addr  = 32'h0600_0000;
    bus_if.iomem_wstrb = 4'h1;
    bus_if.iomem_wdata = 32'h0000_0077;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus_if.iomem_ready !== 1'b0) saw = 1'b1;
    end
    bus_if.iomem_valid = 1'b0;
    bus_if.iomem_wstrb = 4'h0;
    checks++;
    if (saw || bus_if.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL other_page got ready_seen=%b tx_valid=%b exp 0 0", saw, bus_if.tx_valid);
    end
  endtask

  task automatic test_reset_abort();
    bit saw;
    bus_if.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus_write(A_DATA, 32'h0000_00C0 + 32'(i));
    step();
    checks++;
    if (bus_if.tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre_tx_valid got=%b exp=1", bus_if.tx_valid);
    end
    saw = 1'b0;
    bus_if.iomem_valid = 1'b1;
    bus_if.iomem_addr  = A_STATUS;
    bus_if.iomem_wstrb = 4'h0;
    #2 resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus_if.iomem_ready !== 1'b0) saw = 1'b1;
    end
    bus_if.iomem_valid = 1'b0;
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus_if.iomem_ready !== 1'b0) saw = 1'b1;
    end
    checks++;
    if (saw || bus_if.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort got ready_seen=%b tx_valid=%b exp 0 0", saw, bus_if.tx_valid);
    end
    expect_status("abort", 32'h0000_0006);
  endtask

  initial begin
    resetn             = 1'b0;
    bus_if.iomem_valid = 1'b0;
    bus_if.iomem_wstrb = 4'h0;
    bus_if.iomem_addr  = 32'h0;
    bus_if.iomem_wdata = 32'h0;
    bus_if.tx_ready    = 1'b0;
    bus_if.rx_valid    = 1'b0;
    bus_if.rx_data     = 8'h0;
    #1;
    test_reset();
    test_tx_basic();
    test_tx_overflow();
    test_rx_fill();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_iomem_stream_bridge
`default_nettype wire
